// File: rtl/pwm_timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_timer_sequencer
// Purpose  : Walks a host-loaded table of up to four PWM segments. For each
//            segment it writes max/pwm/stop into the timer, pulses start,
//            waits for a rising edge on the timer end indication, then moves
//            on (optionally looping back to segment 0).
// Revision : 1.0 - initial release
// ============================================================================
module pwm_timer_sequencer #(
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_cfg_we,
    input  logic [1:0]    i_cfg_entry,
    input  logic [1:0]    i_cfg_field,
    input  logic [DW-1:0] i_cfg_wdata,
    input  logic          i_run,
    input  logic          i_abort,
    input  logic          i_tmr_end,
    output logic          o_tmr_we,
    output logic [1:0]    o_tmr_addr,
    output logic [DW-1:0] o_tmr_wdata,
    output logic          o_tmr_start,
    output logic          o_busy,
    output logic [1:0]    o_cur_entry,
    output logic          o_seq_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_MAX  = 3'd1,
        S_LD_PWM  = 3'd2,
        S_LD_STOP = 3'd3,
        S_START   = 3'd4,
        S_WAIT    = 3'd5,
        S_NEXT    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic          end_q;
    logic [1:0]    last_idx_q;
    logic          loop_q;
    logic [DW-1:0] max_q  [4];
    logic [DW-1:0] pwm_q  [4];
    logic [DW-1:0] stop_q [4];

    // Table writes are only allowed while the sequencer is idle
    logic w_cfg_ok;
    assign w_cfg_ok = i_cfg_we && (state_q == S_IDLE);

    // Segment table: one register set per entry
    for (genvar g = 0; g < 4; g++) begin : g_entry
        // Capture host writes addressed to this entry's data fields
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                max_q[g]  <= '0;
                pwm_q[g]  <= '0;
                stop_q[g] <= '0;
            end else if (w_cfg_ok && (i_cfg_entry == 2'(g))) begin
                case (i_cfg_field)
                    2'd0:    max_q[g]  <= i_cfg_wdata;
                    2'd1:    pwm_q[g]  <= i_cfg_wdata;
                    2'd2:    stop_q[g] <= i_cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Control register: field 3 ignores the entry index
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_idx_q <= 2'd0;
            loop_q     <= 1'b0;
        end else if (w_cfg_ok && (i_cfg_field == 2'd3)) begin
            last_idx_q <= i_cfg_wdata[1:0];
            loop_q     <= i_cfg_wdata[2];
        end
    end

    // State, segment index and end-indication history
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            end_q   <= i_tmr_end;
        end
    end

    // A level carried over from an earlier segment never looks like an edge
    logic w_end_rise;
    logic w_last;
    assign w_end_rise = i_tmr_end & ~end_q;
    assign w_last     = (idx_q == last_idx_q);

    // Next-state logic; abort overrides every non-idle state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if ((state_q != S_IDLE) && i_abort) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_run && !i_abort) begin
                        state_d = S_LD_MAX;
                        idx_d   = 2'd0;
                    end
                end
                S_LD_MAX:  state_d = S_LD_PWM;
                S_LD_PWM:  state_d = S_LD_STOP;
                S_LD_STOP: state_d = S_START;
                S_START:   state_d = S_WAIT;
                S_WAIT: begin
                    if (w_end_rise) begin
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (!w_last) begin
                        state_d = S_LD_MAX;
                        idx_d   = idx_q + 2'd1;
                    end else if (loop_q) begin
                        state_d = S_LD_MAX;
                        idx_d   = 2'd0;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // Moore outputs decoded purely from the registered state
    always_comb begin
        o_tmr_we    = 1'b0;
        o_tmr_addr  = 2'd0;
        o_tmr_wdata = '0;
        o_tmr_start = 1'b0;
        o_seq_done  = 1'b0;
        case (state_q)
            S_LD_MAX: begin
                o_tmr_we    = 1'b1;
                o_tmr_addr  = 2'd0;
                o_tmr_wdata = max_q[idx_q];
            end
            S_LD_PWM: begin
                o_tmr_we    = 1'b1;
                o_tmr_addr  = 2'd1;
                o_tmr_wdata = pwm_q[idx_q];
            end
            S_LD_STOP: begin
                o_tmr_we    = 1'b1;
                o_tmr_addr  = 2'd2;
                o_tmr_wdata = stop_q[idx_q];
            end
            S_START: o_tmr_start = 1'b1;
            S_NEXT:  o_seq_done  = w_last && !loop_q;
            default: ;
        endcase
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_cur_entry = idx_q;

endmodule
`default_nettype wire
